atomic_unit: RTL

//  Sequencer for RV32A instructions (LR.W, SC.W, AMO*.W) in the MEM stage.

---
 rtl/atomic_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/atomic_unit.sv
// RV32A sequencer for the MEM stage: holds the LR reservation and runs
// read-modify-write bursts on the data-memory port while stalling the pipeline.
module atomic_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned RESV_LSB = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              amo_valid,
    input  logic [4:0]        amo_funct5,
    input  logic [ADDR_W-1:0] amo_addr,
    input  logic [XLEN-1:0]   amo_rs2,
    input  logic              clr_resv,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              atomic_unit_stall,
    output logic [XLEN-1:0]   amo_result,
    output logic              amo_done,
    output logic              amo_misaligned
);
    localparam int unsigned RESV_W = ADDR_W - RESV_LSB;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MODIFY,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              is_lr;
    logic              is_sc;
    logic              misaligned;
    logic              resv_hit;
    logic              resv_valid;
    logic [RESV_W-1:0] resv_addr;

    logic              lr_q;
    logic              sc_q;
    logic              mis_q;
    logic [4:0]        funct5_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   rs2_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   new_q;

    assign is_lr      = (amo_funct5 == F5_LR);
    assign is_sc      = (amo_funct5 == F5_SC);
    assign misaligned = (amo_addr[1:0] != 2'b00);
    assign resv_hit   = resv_valid && (amo_addr[ADDR_W-1:RESV_LSB] == resv_addr);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (amo_valid) begin
                    if (misaligned) begin
                        state_nxt = S_DONE;
                    end else if (is_sc) begin
                        state_nxt = resv_hit ? S_WRITE : S_DONE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ:   if (mem_ack) state_nxt = lr_q ? S_DONE : S_MODIFY;
            S_MODIFY: state_nxt = S_WRITE;
            S_WRITE:  if (mem_ack) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode; address/data/result come straight from registers
    always_comb begin
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        amo_done          = 1'b0;
        amo_misaligned    = 1'b0;
        atomic_unit_stall = 1'b0;
        case (state)
            S_IDLE:   atomic_unit_stall = amo_valid;
            S_READ: begin
                atomic_unit_stall = 1'b1;
                mem_req           = 1'b1;
            end
            S_MODIFY: atomic_unit_stall = 1'b1;
            S_WRITE: begin
                atomic_unit_stall = 1'b1;
                mem_req           = 1'b1;
                mem_we            = 1'b1;
            end
            S_DONE: begin
                amo_done       = 1'b1;
                amo_misaligned = mis_q;
            end
            default: ;
        endcase
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign amo_result = result_q;

    // AMO operation; unlisted encodings fall through to SWAP
    always_comb begin
        new_q = rs2_q;
        case (funct5_q)
            F5_SWAP: new_q = rs2_q;
            F5_ADD:  new_q = old_q + rs2_q;
            F5_XOR:  new_q = old_q ^ rs2_q;
            F5_AND:  new_q = old_q & rs2_q;
            F5_OR:   new_q = old_q | rs2_q;
            F5_MIN:  new_q = ($signed(old_q) < $signed(rs2_q)) ? old_q : rs2_q;
            F5_MAX:  new_q = ($signed(old_q) > $signed(rs2_q)) ? old_q : rs2_q;
            F5_MINU: new_q = (old_q < rs2_q) ? old_q : rs2_q;
            F5_MAXU: new_q = (old_q > rs2_q) ? old_q : rs2_q;
            default: new_q = rs2_q;
        endcase
    end

    // Burst datapath: operands captured on acceptance, held until the burst ends
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_q     <= 1'b0;
            sc_q     <= 1'b0;
            mis_q    <= 1'b0;
            funct5_q <= '0;
            addr_q   <= '0;
            rs2_q    <= '0;
            old_q    <= '0;
            wdata_q  <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (amo_valid) begin
                        lr_q     <= is_lr;
                        sc_q     <= is_sc;
                        mis_q    <= misaligned;
                        funct5_q <= amo_funct5;
                        addr_q   <= {amo_addr[ADDR_W-1:2], 2'b00};
                        rs2_q    <= amo_rs2;
                        if (misaligned) begin
                            result_q <= '0;
                        end else if (is_sc) begin
                            if (resv_hit) begin
                                wdata_q <= amo_rs2;
                            end else begin
                                result_q <= XLEN'(1);
                            end
                        end
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        old_q <= mem_rdata;
                        if (lr_q) result_q <= mem_rdata;
                    end
                end
                S_MODIFY: wdata_q <= new_q;
                S_WRITE: begin
                    if (mem_ack) result_q <= sc_q ? '0 : old_q;
                end
                default: ;
            endcase
        end
    end

    // Reservation; an external clear overrides any set in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else if (clr_resv) begin
            resv_valid <= 1'b0;
        end else begin
            if (state == S_IDLE && amo_valid && !misaligned && is_sc && !resv_hit) begin
                resv_valid <= 1'b0;
            end
            if (state == S_READ && mem_ack && lr_q) begin
                resv_valid <= 1'b1;
                resv_addr  <= addr_q[ADDR_W-1:RESV_LSB];
            end
            if (state == S_WRITE && mem_ack &&
                (sc_q || addr_q[ADDR_W-1:RESV_LSB] == resv_addr)) begin
                resv_valid <= 1'b0;
            end
        end
    end

endmodule
